// File: rtl/mem_to_axi.sv
// Memory-stream slave to AXI4 master bridge: single-word requests become
// single-beat AXI4 transactions (ID 0), with one in-order response per grant.

package mem_to_axi_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic        user;
  } axi_aw_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic        user;
  } axi_ar_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
    logic        user;
  } axi_w_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
    logic       user;
  } axi_b_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
    logic        user;
  } axi_r_t;

  typedef struct packed {
    axi_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   ar_ready;
    logic   w_ready;
    logic   b_valid;
    axi_b_t b;
    logic   r_valid;
    axi_r_t r;
  } axi_resp_t;

endpackage

module mem_to_axi #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4,
  parameter int unsigned MaxTrans  = 4,
  parameter type axi_req_t  = mem_to_axi_pkg::axi_req_t,
  parameter type axi_resp_t = mem_to_axi_pkg::axi_resp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  output logic                   busy_o,
  input  logic                   mem_req_i,
  output logic                   mem_gnt_o,
  input  logic [AddrWidth-1:0]   mem_addr_i,
  input  logic                   mem_we_i,
  input  logic [DataWidth-1:0]   mem_wdata_i,
  input  logic [DataWidth/8-1:0] mem_strb_i,
  output logic                   mem_rvalid_o,
  output logic [DataWidth-1:0]   mem_rdata_o,
  output logic                   mem_err_o,
  output axi_req_t               axi_req_o,
  input  axi_resp_t              axi_resp_i
);

  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam logic [2:0]  Size = 3'($clog2(DataWidth / 8));

  logic [CntW-1:0] r_cnt;
  logic            r_aw_done;
  logic            r_w_done;
  logic            r_last_we;

  logic w_block;
  logic w_write_open;
  logic w_ar_valid;
  logic w_aw_valid;
  logic w_w_valid;
  logic w_ar_hs;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_gnt;
  logic w_rsp;
  logic [IdWidth-1:0] w_id;
  logic w_unused;

  assign w_id     = {IdWidth{1'b0}};
  assign w_unused = ^axi_resp_i;

  // Same-ID reads and writes are unordered on AXI, so a direction change
  // waits until every outstanding response has drained.
  assign w_block = (r_cnt == CntW'(MaxTrans)) ||
                   ((r_cnt != '0) && (mem_we_i != r_last_we));

  // A partially issued write must finish regardless of the block condition.
  assign w_write_open = r_aw_done | r_w_done;

  assign w_ar_valid = rst_ni & mem_req_i & ~mem_we_i & ~w_block;
  assign w_aw_valid = rst_ni & mem_req_i & mem_we_i & ~(w_block & ~w_write_open) & ~r_aw_done;
  assign w_w_valid  = rst_ni & mem_req_i & mem_we_i & ~(w_block & ~w_write_open) & ~r_w_done;

  assign w_ar_hs = w_ar_valid & axi_resp_i.ar_ready;
  assign w_aw_hs = w_aw_valid & axi_resp_i.aw_ready;
  assign w_w_hs  = w_w_valid  & axi_resp_i.w_ready;

  assign w_gnt = mem_req_i & (mem_we_i ? ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs))
                                       : w_ar_hs);
  assign w_rsp = axi_resp_i.r_valid | axi_resp_i.b_valid;

  assign mem_gnt_o = w_gnt;
  assign busy_o    = (r_cnt != '0) | r_aw_done | r_w_done;

  always_comb begin
    axi_req_o           = '0;
    axi_req_o.aw.id     = w_id;
    axi_req_o.aw.addr   = mem_addr_i;
    axi_req_o.aw.size   = Size;
    axi_req_o.aw.burst  = 2'b01;
    axi_req_o.aw_valid  = w_aw_valid;
    axi_req_o.w.data    = mem_wdata_i;
    axi_req_o.w.strb    = mem_strb_i;
    axi_req_o.w.last    = 1'b1;
    axi_req_o.w_valid   = w_w_valid;
    axi_req_o.b_ready   = 1'b1;
    axi_req_o.ar.id     = w_id;
    axi_req_o.ar.addr   = mem_addr_i;
    axi_req_o.ar.size   = Size;
    axi_req_o.ar.burst  = 2'b01;
    axi_req_o.ar_valid  = w_ar_valid;
    axi_req_o.r_ready   = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt     <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_last_we <= 1'b0;
    end else begin
      if (w_gnt && !w_rsp) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (!w_gnt && w_rsp) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_gnt) begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
        r_last_we <= mem_we_i;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end
    end
  end

  // Response path: one register stage after the R or B handshake.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_rvalid_o <= 1'b0;
      mem_rdata_o  <= '0;
      mem_err_o    <= 1'b0;
    end else begin
      mem_rvalid_o <= w_rsp;
      mem_rdata_o  <= axi_resp_i.r_valid ? axi_resp_i.r.data : '0;
      mem_err_o    <= axi_resp_i.r_valid ? axi_resp_i.r.resp[1] :
                      (axi_resp_i.b_valid & axi_resp_i.b.resp[1]);
    end
  end

  a_no_rsp_idle : assert property (@(posedge clk_i) disable iff (!rst_ni)
    w_rsp |-> (r_cnt != '0));
  a_no_rb_both : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(axi_resp_i.r_valid && axi_resp_i.b_valid));
  a_r_last : assert property (@(posedge clk_i) disable iff (!rst_ni)
    axi_resp_i.r_valid |-> axi_resp_i.r.last);
  a_cnt_max : assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_cnt <= CntW'(MaxTrans));
  a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mem_req_i && !mem_gnt_o) |=> (mem_req_i && $stable(mem_addr_i) && $stable(mem_we_i)
                                   && $stable(mem_wdata_i) && $stable(mem_strb_i)));

endmodule

// File: tb/tb_mem_to_axi.sv
// Directed bench for mem_to_axi: drives the AXI slave side by hand and checks
// grants, AXI valids and the in-order memory responses.

module tb_mem_to_axi;
  import mem_to_axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        busy;
  logic        mem_req;
  logic        gnt;
  logic [31:0] addr;
  logic        mem_we;
  logic [63:0] wdata;
  logic [7:0]  strb;
  logic        rvalid;
  logic [63:0] rdata;
  logic        err;
  axi_req_t    areq;
  axi_resp_t   aresp;

  int checks   = 0;
  int failures = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  mem_to_axi dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .busy_o       (busy),
    .mem_req_i    (mem_req),
    .mem_gnt_o    (gnt),
    .mem_addr_i   (addr),
    .mem_we_i     (mem_we),
    .mem_wdata_i  (wdata),
    .mem_strb_i   (strb),
    .mem_rvalid_o (rvalid),
    .mem_rdata_o  (rdata),
    .mem_err_o    (err),
    .axi_req_o    (areq),
    .axi_resp_i   (aresp)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_r(input logic [63:0] d, input logic [1:0] rs);
    aresp.r_valid = 1'b1;
    aresp.r.data  = d;
    aresp.r.resp  = rs;
    aresp.r.last  = 1'b1;
    exp_q.push_back(d);
  endtask

  task automatic drive_b(input logic [1:0] rs);
    aresp.b_valid = 1'b1;
    aresp.b.resp  = rs;
    exp_q.push_back(64'h0);
  endtask

  task automatic clear_resp();
    aresp.r_valid = 1'b0;
    aresp.b_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string tag, input logic exp_err);
    logic [63:0] e;
    e = exp_q.pop_front();
    chk({tag, "_rvalid"}, 64'(rvalid), 64'd1);
    chk({tag, "_rdata"}, rdata, e);
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
  endtask

  initial begin
    rst_n   = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    addr    = '0;
    wdata   = '0;
    strb    = '0;
    aresp   = '0;
    settle();
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_rvalid", 64'(rvalid), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valids", {61'd0, areq.ar_valid, areq.aw_valid, areq.w_valid}, 64'd0);
    chk("rst_readies", {62'd0, areq.b_ready, areq.r_ready}, 64'd3);
    tick();
    tick();
    rst_n = 1'b1;

    // Single read, AR accepted at once, R one cycle later
    tick();
    mem_req = 1'b1; mem_we = 1'b0; addr = 32'h100; aresp.ar_ready = 1'b1;
    settle();
    chk("rd_ar_valid", 64'(areq.ar_valid), 64'd1);
    chk("rd_ar_addr", 64'(areq.ar.addr), 64'h100);
    chk("rd_gnt", 64'(gnt), 64'd1);
    chk("rd_ar_len", 64'(areq.ar.len), 64'd0);
    chk("rd_ar_size", 64'(areq.ar.size), 64'd3);
    chk("rd_ar_burst", 64'(areq.ar.burst), 64'd1);
    chk("rd_ar_id", 64'(areq.ar.id), 64'd0);
    tick();
    mem_req = 1'b0; aresp.ar_ready = 1'b0;
    settle();
    chk("rd_busy", 64'(busy), 64'd1);
    chk("rd_ar_drop", 64'(areq.ar_valid), 64'd0);
    drive_r(64'hDEADBEEF_CAFEF00D, 2'b00);
    tick();
    clear_resp();
    expect_rsp("rd", 1'b0);
    chk("rd_idle", 64'(busy), 64'd0);
    tick();
    chk("rd_rvalid_low", 64'(rvalid), 64'd0);

    // Write with AW ready three cycles before W ready
    mem_req = 1'b1; mem_we = 1'b1; addr = 32'h200;
    wdata = 64'h11223344_55667788; strb = 8'hF0; aresp.aw_ready = 1'b1;
    settle();
    chk("wr_aw_valid", 64'(areq.aw_valid), 64'd1);
    chk("wr_w_valid", 64'(areq.w_valid), 64'd1);
    chk("wr_gnt_early", 64'(gnt), 64'd0);
    chk("wr_aw_addr", 64'(areq.aw.addr), 64'h200);
    chk("wr_w_strb", 64'(areq.w.strb), 64'hF0);
    chk("wr_w_last", 64'(areq.w.last), 64'd1);
    chk("wr_w_data", areq.w.data, 64'h11223344_55667788);
    tick();
    aresp.aw_ready = 1'b0;
    settle();
    chk("wr_aw_dropped", 64'(areq.aw_valid), 64'd0);
    chk("wr_w_held", 64'(areq.w_valid), 64'd1);
    chk("wr_gnt_wait", 64'(gnt), 64'd0);
    chk("wr_busy_partial", 64'(busy), 64'd1);
    tick();
    tick();
    aresp.w_ready = 1'b1;
    settle();
    chk("wr_gnt", 64'(gnt), 64'd1);
    tick();
    mem_req = 1'b0; aresp.w_ready = 1'b0;
    settle();
    chk("wr_w_drop", 64'(areq.w_valid), 64'd0);
    chk("wr_busy", 64'(busy), 64'd1);
    drive_b(2'b00);
    tick();
    clear_resp();
    expect_rsp("wr", 1'b0);
    chk("wr_idle", 64'(busy), 64'd0);

    // Six reads against MaxTrans=4, first R ten cycles after first AR
    aresp.ar_ready = 1'b1; mem_we = 1'b0; mem_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 32'h1000 + 32'(i * 8);
      settle();
      chk("mt_gnt", 64'(gnt), 64'd1);
      tick();
    end
    addr = 32'h1020;
    for (int i = 0; i < 6; i++) begin
      settle();
      chk("mt_full_ar_valid", 64'(areq.ar_valid), 64'd0);
      tick();
    end
    drive_r({32'hA5A5_0000, 32'h1000}, 2'b00);
    settle();
    chk("mt_full_gnt", 64'(gnt), 64'd0);
    tick();
    clear_resp();
    expect_rsp("mt0", 1'b0);
    settle();
    chk("mt_gnt5", 64'(gnt), 64'd1);
    tick();
    addr = 32'h1028;
    settle();
    chk("mt_full2_ar_valid", 64'(areq.ar_valid), 64'd0);
    drive_r({32'hA5A5_0000, 32'h1008}, 2'b00);
    tick();
    clear_resp();
    expect_rsp("mt1", 1'b0);
    settle();
    chk("mt_gnt6", 64'(gnt), 64'd1);
    tick();
    mem_req = 1'b0;
    for (int j = 2; j < 6; j++) begin
      chk("mt_busy", 64'(busy), 64'd1);
      drive_r({32'hA5A5_0000, 32'h1000 + 32'(j * 8)}, 2'b00);
      tick();
      clear_resp();
      expect_rsp("mt", 1'b0);
    end
    chk("mt_idle", 64'(busy), 64'd0);

    // Read outstanding, then a write must wait for the R
    mem_req = 1'b1; mem_we = 1'b0; addr = 32'h300;
    settle();
    chk("dir_rd_gnt", 64'(gnt), 64'd1);
    tick();
    mem_we = 1'b1; addr = 32'h308; wdata = 64'h0BAD_F00D_0000_0001; strb = 8'hFF;
    aresp.aw_ready = 1'b1; aresp.w_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("dir_aw_blocked", 64'(areq.aw_valid), 64'd0);
      chk("dir_w_blocked", 64'(areq.w_valid), 64'd0);
      chk("dir_gnt_blocked", 64'(gnt), 64'd0);
      tick();
    end
    drive_r(64'h3030_3030_3030_3030, 2'b00);
    settle();
    chk("dir_aw_still_blocked", 64'(areq.aw_valid), 64'd0);
    tick();
    clear_resp();
    expect_rsp("dir_rd", 1'b0);
    settle();
    chk("dir_aw_valid", 64'(areq.aw_valid), 64'd1);
    chk("dir_w_valid", 64'(areq.w_valid), 64'd1);
    chk("dir_wr_gnt", 64'(gnt), 64'd1);
    tick();
    mem_req = 1'b0; aresp.aw_ready = 1'b0; aresp.w_ready = 1'b0;
    drive_b(2'b00);
    tick();
    clear_resp();
    expect_rsp("dir_wr", 1'b0);
    chk("dir_idle", 64'(busy), 64'd0);

    // Error responses
    mem_req = 1'b1; mem_we = 1'b0; addr = 32'h400;
    settle();
    chk("slv_gnt", 64'(gnt), 64'd1);
    tick();
    mem_req = 1'b0;
    drive_r(64'h4444_0000_0000_4444, 2'b10);
    tick();
    clear_resp();
    expect_rsp("slverr", 1'b1);
    mem_req = 1'b1; addr = 32'h408;
    settle();
    chk("dec_gnt", 64'(gnt), 64'd1);
    tick();
    mem_req = 1'b0;
    drive_r(64'h4444_0000_0000_4408, 2'b11);
    tick();
    clear_resp();
    expect_rsp("decerr", 1'b1);
    tick();
    chk("err_cleared", 64'(err), 64'd0);

    // Reset with a write half issued
    mem_req = 1'b1; mem_we = 1'b1; addr = 32'h500; wdata = 64'h5;
    aresp.aw_ready = 1'b1; aresp.w_ready = 1'b0;
    settle();
    chk("mr_aw_valid", 64'(areq.aw_valid), 64'd1);
    tick();
    aresp.aw_ready = 1'b0;
    settle();
    chk("mr_busy_before", 64'(busy), 64'd1);
    chk("mr_w_valid_before", 64'(areq.w_valid), 64'd1);
    rst_n = 1'b0;
    settle();
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_aw_valid_rst", 64'(areq.aw_valid), 64'd0);
    chk("mr_w_valid_rst", 64'(areq.w_valid), 64'd0);
    chk("mr_gnt", 64'(gnt), 64'd0);
    chk("mr_rvalid", 64'(rvalid), 64'd0);
    mem_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    settle();
    chk("mr_busy_after", 64'(busy), 64'd0);

    // Bridge usable again after reset
    mem_req = 1'b1; mem_we = 1'b0; addr = 32'h600; aresp.ar_ready = 1'b1;
    settle();
    chk("post_gnt", 64'(gnt), 64'd1);
    tick();
    mem_req = 1'b0;
    drive_r(64'h6060_6060_0000_0600, 2'b00);
    tick();
    clear_resp();
    expect_rsp("post", 1'b0);
    chk("post_idle", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_to_axi.md
Name: mem_to_axi

Overview:
- Memory-stream slave to AXI4 master bridge: accepts single-word memory requests and issues single-beat AXI4 transactions (LEN=0, INCR, full-width SIZE).
- Returns one in-order response per granted request.
- Sits between cores/DMA-style memory-stream initiators and the AXI interconnect.
- Complement of the AXI-slave-to-memory bridge, so memory-port masters can reach AXI targets.

Parameters:
- AddrWidth, 32, memory/AXI address width.
- DataWidth, 64, memory/AXI data width; power of two, >= 8.
- IdWidth, 4, AXI ID width; all transactions use ID 0.
- MaxTrans, 4, maximum outstanding transactions; >= 1.
- axi_req_t, logic, AXI4+ATOP request struct type.
- axi_resp_t, logic, AXI4+ATOP response struct type.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset.
- busy_o  out  1  transactions outstanding or a write partially issued.
- mem_req_i  in  1  request valid; held stable with all fields until mem_gnt_o.
- mem_gnt_o  out  1  request accepted.
- mem_addr_i  in  AddrWidth  byte address.
- mem_we_i  in  1  1 = write, 0 = read.
- mem_wdata_i  in  DataWidth  write data.
- mem_strb_i  in  DataWidth/8  byte strobe.
- mem_rvalid_o  out  1  response valid, one per grant, in grant order.
- mem_rdata_o  out  DataWidth  read data; '0 for write responses.
- mem_err_o  out  1  AXI RESP[1] of the response (SLVERR/DECERR).
- axi_req_o  out  axi_req_t  AXI master request.
- axi_resp_i  in  axi_resp_t  AXI master response.

Interface description:
- One clock, clk_i.
- Reset rst_ni is asynchronous and active-low.

Behaviour:
- Reset values:
  - All AXI valid outputs 0.
  - mem_gnt_o = 0, mem_rvalid_o = 0, mem_rdata_o = '0, mem_err_o = 0, busy_o = 0.
  - Outstanding counter = 0, aw_done/w_done = 0, last direction = read.
- Static AXI fields:
  - id = 0, len = 0, size = log2(DataWidth/8), burst = INCR.
  - cache, prot, qos, region, atop, user all '0.
  - w.last = 1.
  - b_ready = r_ready = 1 constantly.
- Blocking condition: block = (cnt == MaxTrans) OR (cnt != 0 AND mem_we_i != last_dir).
  - Same-ID reads and writes are unordered on AXI, so a direction switch waits for all outstanding responses to drain. This guarantees in-order mem responses.
- Read path:
  - ar_valid = mem_req_i & !mem_we_i & !block.
  - ar.addr = mem_addr_i.
  - mem_gnt_o = ar_valid & ar_ready.
- Write path:
  - aw_valid = mem_req_i & mem_we_i & !block & !aw_done.
  - w_valid = mem_req_i & mem_we_i & !block & !w_done.
  - w.data = mem_wdata_i, w.strb = mem_strb_i.
  - An AW or W handshake completing alone sets its done flag.
  - mem_gnt_o = (aw_done | aw handshake) & (w_done | w handshake).
  - On grant, both flags clear.
  - While a flag is set, block is ignored; the counter cannot change direction mid-write because flags only exist for the current request.
- Valid stability: once asserted, a valid stays high until its handshake. This relies on the upstream hold rule and on block not asserting mid-request; count only grows on grant.
- Counter:
  - +1 on grant, -1 on an R or B handshake.
  - Both in the same cycle: unchanged.
  - last_dir <= mem_we_i on grant.
- Response, registered with 1 cycle latency after the AXI R/B handshake:
  - mem_rvalid_o <= r_valid | b_valid.
  - mem_rdata_o <= r.data on R, '0 on B.
  - mem_err_o <= resp[1].
  - R and B simultaneously cannot occur, because the direction rule prevents it; flag by assertion.
- busy_o = (cnt != 0) | aw_done | w_done.
- Assertions:
  - No R/B while cnt == 0.
  - r.last == 1 on every R.
  - Counter never exceeds MaxTrans.
  - mem fields stable while mem_req_i & !mem_gnt_o.
- Reset mid-operation: all state cleared asynchronously; in-flight AXI responses after reset are not tracked (system-level reset required).

Test Plan:
- Single read, addr 0x100, AR ready immediately, R data 0xDEADBEEF_CAFEF00D, resp OKAY one cycle later -> gnt same cycle as AR handshake; mem_rvalid_o one cycle after R with that data, err 0.
- Write 0x200, strb 0xF0, AW ready 3 cycles before W ready -> aw_valid drops after its handshake, w_valid held; gnt only on W handshake; B OKAY -> mem_rvalid_o=1, rdata 0.
- MaxTrans=4, six back-to-back reads, R delayed 10 cycles -> 4 grants, 5th held (ar_valid=0) until first R, then granted; 6 responses in order; busy_o falls after last.
- Read then write at cnt=1, R delayed 5 cycles -> write's aw_valid/w_valid stay 0 until R received, then issued.
- Read returning RESP=SLVERR (2'b10) -> mem_err_o=1 with rvalid; DECERR likewise.
- Assert rst_ni low after AW handshake with W pending -> all outputs and flags return to reset values immediately; busy_o=0.
